// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update controller.
package btb_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } upd_entry_t;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t    CNT_WNT    = 2'b01;
  localparam bht_cnt_t    CNT_THRESH = 2'd2;
  localparam logic [31:0] PC_STEP    = 32'd4;

  // 2-bit saturating counter step.
  function automatic bht_cnt_t cnt_update(input bht_cnt_t c, input logic taken);
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// EX resolve bus in, BTB write port out; master = EX/BTB side, slave = controller.
interface btb_update_ctrl_if;
  logic        ex_valid;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_PC;
  logic [31:0] ex_target;
  logic        ex_predicted;
  logic [31:0] ex_pred_PC;
  logic        wr_req;
  logic [31:0] wr_PC;
  logic [31:0] wr_predicted_PC;

  modport master (
    output ex_valid, ex_is_jump, ex_taken, ex_PC, ex_target, ex_predicted, ex_pred_PC,
    input  wr_req, wr_PC, wr_predicted_PC
  );

  modport slave (
    input  ex_valid, ex_is_jump, ex_taken, ex_PC, ex_target, ex_predicted, ex_pred_PC,
    output wr_req, wr_PC, wr_predicted_PC
  );
endinterface

// File: rtl/btb_upd_fifo.sv
// Update queue: sync FIFO with registered count/full; BTB_UPD_COALESCE_EN merges same-PC updates in place.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  upd_entry_t                  push_data,
  input  logic                        pop,
  output upd_entry_t                  head_c,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned QCNT_W = PTR_W + 1;

  upd_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [QCNT_W-1:0]   count_nxt;
  logic                hit;
  logic [PTR_W-1:0]    hit_idx;
  logic                accept;

`ifdef BTB_UPD_COALESCE_EN
  // Newest live match wins; the head leaving this edge is excluded.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((QCNT_W'(k) < count) && !(pop && (k == 0)) &&
          (mem[rd_ptr + PTR_W'(k)].pc == push_data.pc)) begin
        hit     = 1'b1;
        hit_idx = rd_ptr + PTR_W'(k);
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_idx = '0;
`endif

  assign head_c    = mem[rd_ptr];
  assign accept    = push && !hit && (!full || pop);
  assign drop_c    = push && !hit && full && !pop;
  assign count_nxt = count + QCNT_W'(accept) - QCNT_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == QCNT_W'(DEPTH));
    end
  end

  // Storage needs no reset; only slots inside count are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (accept)       mem[wr_ptr] <= push_data;
    if (push && hit)  mem[hit_idx].target <= push_data.target;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: resolves EX branches, redirects fetch, filters BTB writes via a 2-bit BHT.
// Optional in-place coalescing of queued updates with `define BTB_UPD_COALESCE_EN.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned BHT_ADDR_LEN = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  btb_update_ctrl_if.slave              bus,
  input  logic                          freeze,
  output logic                          redirect_valid,
  output logic [31:0]                   redirect_PC,
  output logic [$clog2(FIFO_DEPTH):0]   q_count,
  output logic                          q_full,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [31:0]                   mispredict_cnt
);

  localparam int unsigned BHT_ENTRIES = 1 << BHT_ADDR_LEN;

  bht_cnt_t                bht [BHT_ENTRIES];
  logic [BHT_ADDR_LEN-1:0] bht_idx;
  bht_cnt_t                cnt_cur;
  bht_cnt_t                cnt_nxt;
  logic [31:0]             pc_seq;
  logic [31:0]             actual_next;
  logic [31:0]             pred_next;
  logic                    mispredict;
  logic                    taken_upd;
  logic                    nt_upd;
  logic                    push;
  logic                    pop;
  logic                    drop_c;
  upd_entry_t              push_data;
  upd_entry_t              head_c;

  assign bht_idx = bus.ex_PC[BHT_ADDR_LEN+1:2];
  assign cnt_cur = bht[bht_idx];
  assign cnt_nxt = cnt_update(cnt_cur, bus.ex_taken);

  // Resolve, mispredict detect and update filtering.
  always_comb begin
    pc_seq      = bus.ex_PC + PC_STEP;
    actual_next = (bus.ex_is_jump || bus.ex_taken) ? bus.ex_target : pc_seq;
    pred_next   = bus.ex_predicted ? bus.ex_pred_PC : pc_seq;
    mispredict  = (actual_next != pred_next);
    taken_upd   = 1'b0;
    nt_upd      = 1'b0;
    if (bus.ex_is_jump || (bus.ex_taken && (cnt_nxt >= CNT_THRESH))) begin
      taken_upd = !bus.ex_predicted || (bus.ex_pred_PC != bus.ex_target);
    end else if (!bus.ex_taken && (cnt_nxt < CNT_THRESH)) begin
      // No valid bit in the BTB: a cold branch gets its entry pointed at the fall-through.
      nt_upd = bus.ex_predicted && (bus.ex_pred_PC != pc_seq);
    end
    push             = bus.ex_valid && (taken_upd || nt_upd);
    push_data.pc     = bus.ex_PC;
    push_data.target = taken_upd ? bus.ex_target : pc_seq;
  end

  assign pop = (q_count != '0) && !freeze;

  btb_upd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_c    (head_c),
    .count     (q_count),
    .full      (q_full),
    .drop_c    (drop_c)
  );

  // Counter table; written same edge so the next resolve reads the fresh value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_WNT;
    end else if (bus.ex_valid && !bus.ex_is_jump) begin
      bht[bht_idx] <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid      <= 1'b0;
      redirect_PC         <= '0;
      mispredict_cnt      <= '0;
      drop_cnt            <= '0;
      bus.wr_req          <= 1'b0;
      bus.wr_PC           <= '0;
      bus.wr_predicted_PC <= '0;
    end else begin
      redirect_valid <= bus.ex_valid && mispredict;
      if (bus.ex_valid && mispredict) begin
        redirect_PC    <= actual_next;
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
      if (drop_c && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + CNT_W'(1);
      bus.wr_req <= pop;
      if (pop) begin
        bus.wr_PC           <= head_c.pc;
        bus.wr_predicted_PC <= head_c.target;
      end
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed vector table, reset corner, then random run against a queue model.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic        redirect_valid;
  logic [31:0] redirect_PC;
  logic [2:0]  q_count;
  logic        q_full;
  logic [15:0] drop_cnt;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_update_ctrl_if bus ();

  btb_update_ctrl #(
    .BHT_ADDR_LEN(8),
    .FIFO_DEPTH  (4),
    .CNT_W       (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .freeze         (freeze),
    .redirect_valid (redirect_valid),
    .redirect_PC    (redirect_PC),
    .q_count        (q_count),
    .q_full         (q_full),
    .drop_cnt       (drop_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct {
    logic        v, j, t;
    logic [31:0] pc, tgt;
    logic        pr;
    logic [31:0] ppc;
    logic        frz;
    logic        rv;
    logic [31:0] rpc;
    logic        wr;
    logic [31:0] wpc, wdat;
    int          qc, mc, dc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tg;
  } ent_t;

  vec_t tbl[$];

  // reference model state
  ent_t        mq[$];
  int          m_bht[256];
  logic        m_rv, m_wr;
  logic [31:0] m_rpc, m_wpc, m_wdat, m_mc;
  int          m_dc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, j, t, input logic [31:0] pc, tgt,
                       input logic pr, input logic [31:0] ppc, input logic frz);
    bus.ex_valid     = v;
    bus.ex_is_jump   = j;
    bus.ex_taken     = t;
    bus.ex_PC        = pc;
    bus.ex_target    = tgt;
    bus.ex_predicted = pr;
    bus.ex_pred_PC   = ppc;
    freeze           = frz;
  endtask

  task automatic add(input logic v, j, t, input logic [31:0] pc, tgt, input logic pr,
                     input logic [31:0] ppc, input logic frz, input logic rv,
                     input logic [31:0] rpc, input logic wr, input logic [31:0] wpc, wdat,
                     input int qc, mc, dc);
    vec_t r;
    r.v = v; r.j = j; r.t = t; r.pc = pc; r.tgt = tgt; r.pr = pr; r.ppc = ppc; r.frz = frz;
    r.rv = rv; r.rpc = rpc; r.wr = wr; r.wpc = wpc; r.wdat = wdat;
    r.qc = qc; r.mc = mc; r.dc = dc;
    tbl.push_back(r);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 256; i++) m_bht[i] = 1;
    m_rv = 0; m_wr = 0; m_rpc = 0; m_wpc = 0; m_wdat = 0; m_mc = 0; m_dc = 0;
  endtask

  // One clock edge of the specified behaviour, written over a queue and integer counters.
  task automatic model_step(input logic v, j, t, input logic [31:0] pc, tgt,
                            input logic pr, input logic [31:0] ppc, input logic frz);
    logic [31:0] p4, act, prd;
    int          c, idx, hit;
    logic        upd;
    ent_t        e;
    if (mq.size() > 0 && !frz) begin
      m_wr = 1; m_wpc = mq[0].pc; m_wdat = mq[0].tg; mq.delete(0);
    end else begin
      m_wr = 0;
    end
    m_rv = 0;
    if (v) begin
      p4  = pc + 32'd4;
      act = (j || t) ? tgt : p4;
      prd = pr ? ppc : p4;
      if (act != prd) begin m_rv = 1; m_rpc = act; m_mc = m_mc + 1; end
      upd = 0;
      e.pc = pc;
      e.tg = tgt;
      if (j) begin
        upd = !pr || (ppc != tgt);
      end else begin
        idx = int'((pc >> 2) & 32'hFF);
        c = m_bht[idx];
        c = t ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
        m_bht[idx] = c;
        if (t) upd = (c >= 2) && (!pr || (ppc != tgt));
        else begin
          upd  = (c < 2) && pr && (ppc != p4);
          e.tg = p4;
        end
      end
      if (upd) begin
        hit = -1;
`ifdef BTB_UPD_COALESCE_EN
        foreach (mq[i]) if (mq[i].pc == pc) hit = i;
`endif
        if (hit >= 0) mq[hit].tg = e.tg;
        else if (mq.size() < 4) mq.push_back(e);
        else if (m_dc < 65535) m_dc = m_dc + 1;
      end
    end
  endtask

  task automatic check_model();
    chk("rnd_wr_req", 32'(bus.wr_req), 32'(m_wr));
    if (m_wr) begin
      chk("rnd_wr_PC", bus.wr_PC, m_wpc);
      chk("rnd_wr_data", bus.wr_predicted_PC, m_wdat);
    end
    chk("rnd_redirect_valid", 32'(redirect_valid), 32'(m_rv));
    if (m_rv) chk("rnd_redirect_PC", redirect_PC, m_rpc);
    chk("rnd_q_count", 32'(q_count), 32'(mq.size()));
    chk("rnd_q_full", 32'(q_full), 32'(mq.size() == 4));
    chk("rnd_drop_cnt", 32'(drop_cnt), 32'(m_dc));
    chk("rnd_mispredict_cnt", mispredict_cnt, m_mc);
  endtask

  initial begin
    logic        rv, rj, rt, rpr, rfrz;
    logic [31:0] rpc, rtgt, rppc;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_req", 32'(bus.wr_req), 0);
    chk("rst_wr_PC", bus.wr_PC, 0);
    chk("rst_wr_data", bus.wr_predicted_PC, 0);
    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_redirect_PC", redirect_PC, 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_q_full", 32'(q_full), 0);
    chk("rst_counters", 32'(drop_cnt) | mispredict_cnt, 0);
    rst_n = 1'b1;

    // v j t pc tgt pr ppc frz | rv rpc wr wpc wdat qc mc dc
    add(1,0,1,'h100,'h200,0,0,0,      1,'h200,0,0,0,            1,1,0);
    add(1,0,1,'h100,'h200,1,'h200,0,  0,0,1,'h100,'h200,        0,1,0);
    add(1,1,0,'h40,'h80,0,0,0,        1,'h80,0,0,0,             1,2,0);
    add(0,0,0,0,0,0,0,0,              0,0,1,'h40,'h80,          0,2,0);
    add(1,0,0,'h100,'h200,1,'h200,0,  1,'h104,0,0,0,            0,3,0);
    add(1,0,0,'h100,'h200,1,'h200,0,  1,'h104,0,0,0,            1,4,0);
    add(0,0,0,0,0,0,0,0,              0,0,1,'h100,'h104,        0,4,0);
    for (int i = 0; i < 6; i++)
      add(1,1,0,32'h1000+32'(16*i),32'h2000+32'(16*i),0,0,1,
          1,32'h2000+32'(16*i),0,0,0, (i < 3) ? i+1 : 4, 5+i, (i < 4) ? 0 : i-3);
    for (int i = 0; i < 4; i++)
      add(0,0,0,0,0,0,0,0, 0,0,1,32'h1000+32'(16*i),32'h2000+32'(16*i), 3-i,10,2);
    add(0,0,0,0,0,0,0,0,              0,0,0,0,0,                0,10,2);
    add(1,1,0,'h40,'h80,0,0,1,        1,'h80,0,0,0,             1,11,2);
`ifdef BTB_UPD_COALESCE_EN
    add(1,1,0,'h40,'hC0,0,0,1,        1,'hC0,0,0,0,             1,12,2);
    add(0,0,0,0,0,0,0,0,              0,0,1,'h40,'hC0,          0,12,2);
    add(0,0,0,0,0,0,0,0,              0,0,0,0,0,                0,12,2);
`else
    add(1,1,0,'h40,'hC0,0,0,1,        1,'hC0,0,0,0,             2,12,2);
    add(0,0,0,0,0,0,0,0,              0,0,1,'h40,'h80,          1,12,2);
    add(0,0,0,0,0,0,0,0,              0,0,1,'h40,'hC0,          0,12,2);
`endif
    add(0,0,0,0,0,0,0,0,              0,0,0,0,0,                0,12,2);

    foreach (tbl[n]) begin
      drive(tbl[n].v, tbl[n].j, tbl[n].t, tbl[n].pc, tbl[n].tgt, tbl[n].pr, tbl[n].ppc, tbl[n].frz);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_redirect_valid", n), 32'(redirect_valid), 32'(tbl[n].rv));
      if (tbl[n].rv) chk($sformatf("vec%0d_redirect_PC", n), redirect_PC, tbl[n].rpc);
      chk($sformatf("vec%0d_wr_req", n), 32'(bus.wr_req), 32'(tbl[n].wr));
      if (tbl[n].wr) begin
        chk($sformatf("vec%0d_wr_PC", n), bus.wr_PC, tbl[n].wpc);
        chk($sformatf("vec%0d_wr_data", n), bus.wr_predicted_PC, tbl[n].wdat);
      end
      chk($sformatf("vec%0d_q_count", n), 32'(q_count), 32'(tbl[n].qc));
      chk($sformatf("vec%0d_q_full", n), 32'(q_full), 32'(tbl[n].qc == 4));
      chk($sformatf("vec%0d_mispredict_cnt", n), mispredict_cnt, 32'(tbl[n].mc));
      chk($sformatf("vec%0d_drop_cnt", n), 32'(drop_cnt), 32'(tbl[n].dc));
    end

    // Async reset while draining with a live redirect pulse.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'h500 + 32'(4*i), 32'h600 + 32'(4*i), 0, 0, 1);
      @(posedge clk);
      #1;
    end
    drive(1, 1, 0, 32'h50C, 32'h60C, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_wr_req", 32'(bus.wr_req), 1);
    chk("pre_rst_redirect_valid", 32'(redirect_valid), 1);
    chk("pre_rst_q_count", 32'(q_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_req", 32'(bus.wr_req), 0);
    chk("mid_rst_redirect_valid", 32'(redirect_valid), 0);
    chk("mid_rst_q_count", 32'(q_count), 0);
    chk("mid_rst_mispredict_cnt", mispredict_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_wr_req", 32'(bus.wr_req), 0);
      chk("post_rst_q_count", 32'(q_count), 0);
    end

    // Randomised run against the reference model.
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rfrz = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) rfrz = ~rfrz;
      rv   = ($urandom_range(0, 3) != 0);
      rj   = ($urandom_range(0, 3) == 0);
      rt   = 1'($urandom_range(0, 1));
      rpr  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
      else rpc = 32'h400 + 32'(4 * $urandom_range(0, 7)) + (($urandom_range(0, 3) == 0) ? 32'h400 : 32'h0);
      rtgt = 32'h3000 + 32'(4 * $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       rppc = rtgt;
        1:       rppc = rpc + 32'd4;
        default: rppc = 32'h3000 + 32'(4 * $urandom_range(0, 3));
      endcase
      drive(rv, rj, rt, rpc, rtgt, rpr, rppc, rfrz);
      model_step(rv, rj, rt, rpc, rtgt, rpr, rppc, rfrz);
      @(posedge clk);
      #1;
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
